// File: rtl/out_fm_tile_writeback.sv
// out_fm_tile_writeback
//   Streams one Tn x Tr x Tc output tile from the on-chip tile buffer back to
//   external out_fm memory (N x R x C layout). Elements that fall outside the
//   feature map are zero-fill padding and are dropped, not written.
//
//   Optional feature: define OUT_FM_RELU_EN to clamp negative write data to 0.
//   Timing is the same with or without it.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   store_start                one-cycle pulse, starts a store (IDLE only)
//   tile_base_n/row/col        tile origin, sampled on store_start
//   store_busy                 high from the cycle after start through store_done
//   store_done                 one-cycle completion pulse
//   buf_rd_addr/buf_rd_ena     tile buffer read port
//   buf_rd_data                read data, captured BUF_LAT edges after the
//                              edge that launched the matching buf_rd_ena
//   out_fm_wr_addr/data/ena    external write port (always accepts)
module out_fm_tile_writeback #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int N       = 128,
  parameter int R       = 128,
  parameter int C       = 128,
  parameter int Tn      = 16,
  parameter int Tr      = 64,
  parameter int Tc      = 16,
  parameter int BUF_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          store_start,
  input  logic [AW-1:0] tile_base_n,
  input  logic [AW-1:0] tile_base_row,
  input  logic [AW-1:0] tile_base_col,
  output logic          store_busy,
  output logic          store_done,
  output logic [AW-1:0] buf_rd_addr,
  output logic          buf_rd_ena,
  input  logic [DW-1:0] buf_rd_data,
  output logic [AW-1:0] out_fm_wr_addr,
  output logic [DW-1:0] out_fm_wr_data,
  output logic          out_fm_wr_ena
);

  // Side pipeline stage 0 is loaded on the same edge as buf_rd_ena, so the
  // last stage lines up with buf_rd_data on the capture edge.
  localparam int STAGES = BUF_LAT - 1;
  localparam int DCW    = (BUF_LAT > 1) ? $clog2(BUF_LAT) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(BUF_LAT - 1);
  localparam logic [AW-1:0]  TN_LAST = AW'(Tn - 1);
  localparam logic [AW-1:0]  TR_LAST = AW'(Tr - 1);
  localparam logic [AW-1:0]  TC_LAST = AW'(Tc - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;

  logic [AW-1:0] base_n, base_row, base_col;
  logic [AW-1:0] tn, tr, tc, lin;
  logic [DCW-1:0] dcnt;

  logic [STAGES:0]         vld_pipe, inr_pipe;
  logic [STAGES:0][AW-1:0] adr_pipe;

  logic [AW-1:0] n_abs, row_abs, col_abs, ext_addr;
  logic          in_range, last_rd;
  logic [DW-1:0] wr_data_nxt;

  assign n_abs    = base_n + tn;
  assign row_abs  = base_row + tr;
  assign col_abs  = base_col + tc;
  assign in_range = (n_abs < AW'(N)) && (row_abs < AW'(R)) && (col_abs < AW'(C));
  assign ext_addr = n_abs * AW'(R * C) + row_abs * AW'(C) + col_abs;
  assign last_rd  = (tn == TN_LAST) && (tr == TR_LAST) && (tc == TC_LAST);

`ifdef OUT_FM_RELU_EN
  assign wr_data_nxt = buf_rd_data[DW-1] ? '0 : buf_rd_data;
`else
  assign wr_data_nxt = buf_rd_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base_n         <= '0;
      base_row       <= '0;
      base_col       <= '0;
      tn             <= '0;
      tr             <= '0;
      tc             <= '0;
      lin            <= '0;
      dcnt           <= '0;
      vld_pipe       <= '0;
      inr_pipe       <= '0;
      adr_pipe       <= '0;
      store_busy     <= 1'b0;
      store_done     <= 1'b0;
      buf_rd_addr    <= '0;
      buf_rd_ena     <= 1'b0;
      out_fm_wr_addr <= '0;
      out_fm_wr_data <= '0;
      out_fm_wr_ena  <= 1'b0;
    end else begin
      buf_rd_ena <= 1'b0;
      store_done <= 1'b0;

      // Per-read side pipeline: valid, in_range, external address.
      vld_pipe[0] <= (state == READ);
      inr_pipe[0] <= in_range;
      adr_pipe[0] <= ext_addr;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        inr_pipe[s] <= inr_pipe[s-1];
        adr_pipe[s] <= adr_pipe[s-1];
      end

      // Write side: clipped elements never reach the write strobe.
      out_fm_wr_ena <= vld_pipe[STAGES] & inr_pipe[STAGES];
      if (vld_pipe[STAGES] && inr_pipe[STAGES]) begin
        out_fm_wr_addr <= adr_pipe[STAGES];
        out_fm_wr_data <= wr_data_nxt;
      end

      case (state)
        IDLE: begin
          store_busy <= store_start;
          if (store_start) begin
            base_n   <= tile_base_n;
            base_row <= tile_base_row;
            base_col <= tile_base_col;
            tn       <= '0;
            tr       <= '0;
            tc       <= '0;
            lin      <= '0;
            state    <= READ;
          end
        end
        READ: begin
          // Buffer address is tn*Tr*Tc + tr*Tc + tc, i.e. the linear read index.
          buf_rd_ena  <= 1'b1;
          buf_rd_addr <= lin;
          lin         <= lin + 1'b1;
          if (tc == TC_LAST) begin
            tc <= '0;
            if (tr == TR_LAST) begin
              tr <= '0;
              tn <= tn + 1'b1;
            end else begin
              tr <= tr + 1'b1;
            end
          end else begin
            tc <= tc + 1'b1;
          end
          if (last_rd) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == DLAST) state <= DONE;
        end
        DONE: begin
          store_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_fm_tile_writeback.sv
// Bench for out_fm_tile_writeback: small geometry (N=4, R=C=8, Tn=2, Tr=Tc=4,
// BUF_LAT=2). Expected writes are pushed to a scoreboard queue when a store is
// started and popped as the DUT writes. Cycle k = state visible after the k-th
// rising edge counted from the edge that samples store_start (k=0).
module tb_out_fm_tile_writeback;
  localparam int AW = 32, DW = 32;
  localparam int N = 4, R = 8, C = 8, TN = 2, TR = 4, TC = 4, LAT = 2;
  localparam int T = TN * TR * TC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          store_start = 1'b0;
  logic [AW-1:0] tile_base_n = '0, tile_base_row = '0, tile_base_col = '0;
  logic          store_busy, store_done, buf_rd_ena, out_fm_wr_ena;
  logic [AW-1:0] buf_rd_addr, out_fm_wr_addr;
  logic [DW-1:0] buf_rd_data, out_fm_wr_data;

  always #5 clk = ~clk;

  out_fm_tile_writeback #(
    .AW(AW), .DW(DW), .N(N), .R(R), .C(C),
    .Tn(TN), .Tr(TR), .Tc(TC), .BUF_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .store_start(store_start),
    .tile_base_n(tile_base_n), .tile_base_row(tile_base_row),
    .tile_base_col(tile_base_col),
    .store_busy(store_busy), .store_done(store_done),
    .buf_rd_addr(buf_rd_addr), .buf_rd_ena(buf_rd_ena),
    .buf_rd_data(buf_rd_data),
    .out_fm_wr_addr(out_fm_wr_addr), .out_fm_wr_data(out_fm_wr_data),
    .out_fm_wr_ena(out_fm_wr_ena)
  );

  // Tile buffer: one register stage, so data is ready LAT=2 edges after the
  // edge that launched buf_rd_ena.
  logic [DW-1:0] mem [0:T-1];
  logic [DW-1:0] rd_q = '0;
  always @(posedge clk) if (buf_rd_ena) rd_q <= mem[buf_rd_addr[4:0]];
  assign buf_rd_data = rd_q;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];

  int passed = 0, total = 0;
  int cyc = 0, start_cyc = 0, rd_exp = 0, done_cnt = 0, exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef OUT_FM_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic load_mem();
    for (int i = 0; i < T; i++) mem[i] = DW'(i);
  endtask

  // Reference: walk the tile, keep only in-map elements.
  task automatic expect_tile(input int bn, input int br, input int bc);
    wr_t e;
    for (int k = 0; k < T; k++) begin
      int n, row, col;
      n   = bn + k / (TR * TC);
      row = br + (k / TC) % TR;
      col = bc + k % TC;
      if (n < N && row < R && col < C) begin
        e.cyc  = k + 1 + LAT;
        e.addr = AW'(n * R * C + row * C + col);
        e.data = relu(mem[k]);
        sb.push_back(e);
      end
    end
    exp_done = T + LAT + 1;
  endtask

  task automatic start(input int bn, input int br, input int bc);
    @(negedge clk);
    tile_base_n   = AW'(bn);
    tile_base_row = AW'(br);
    tile_base_col = AW'(bc);
    store_start   = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    rd_exp    = 0;
    @(negedge clk);
    store_start = 1'b0;
    chk("busy_after_start", store_busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("busy_after_done", store_busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_ena"}, out_fm_wr_ena, 0);
    chk({tag, "_wr_addr"}, out_fm_wr_addr, 0);
    chk({tag, "_wr_data"}, out_fm_wr_data, 0);
    chk({tag, "_rd_ena"}, buf_rd_ena, 0);
    chk({tag, "_rd_addr"}, buf_rd_addr, 0);
    chk({tag, "_busy"}, store_busy, 0);
    chk({tag, "_done"}, store_done, 0);
  endtask

  // Output monitor.
  always @(negedge clk) begin
    int rel;
    wr_t e;
    if (!rst) begin
      rel = cyc - start_cyc;
      if (buf_rd_ena) begin
        chk("rd_addr", buf_rd_addr, rd_exp);
        chk("rd_cyc", rel, rd_exp + 1);
        rd_exp++;
      end
      if (out_fm_wr_ena) begin
        if (sb.size() == 0) chk("wr_extra", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("wr_addr", out_fm_wr_addr, e.addr);
          chk("wr_data", out_fm_wr_data, e.data);
          chk("wr_cyc", rel, e.cyc);
        end
      end
      if (store_done) begin
        done_cnt++;
        chk("done_cyc", rel, exp_done);
        chk("busy_at_done", store_busy, 1);
      end
    end
  end

  initial begin
    int d0;
    load_mem();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Interior tile.
    expect_tile(0, 0, 0);
    start(0, 0, 0);
    wait_done();

    // Edge clipping: only n=3, rows 6..7, cols 6..7 land inside the map.
    chk("clip_count_model", 0, sb.size());
    expect_tile(3, 6, 6);
    chk("clip_sb_size", sb.size(), 4);
    start(3, 6, 6);
    wait_done();

    // Restart ignored: second start with another base at cycle 10.
    d0 = done_cnt;
    expect_tile(0, 0, 0);
    start(0, 0, 0);
    while (cyc - start_cyc < 9) @(negedge clk);
    tile_base_n = 1; tile_base_row = 2; tile_base_col = 3;
    store_start = 1'b1;
    @(negedge clk);
    store_start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("one_done", done_cnt, d0 + 1);

    // Reset mid-store at cycle 12.
    expect_tile(0, 0, 0);
    start(0, 0, 0);
    do begin
      @(posedge clk);
      #1;
    end while (cyc - start_cyc < 12);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_no_busy", store_busy, 0);
    expect_tile(0, 0, 0);
    start(0, 0, 0);
    wait_done();

    // Negative word at buffer addr 5 (external addr 9).
    mem[5] = 32'hFFFF_FFF0;
    expect_tile(0, 0, 0);
    start(0, 0, 0);
    wait_done();
    load_mem();

    // Fully outside the map: no writes, store_done still on time.
    d0 = done_cnt;
    expect_tile(4, 0, 0);
    chk("outside_sb_size", sb.size(), 0);
    start(4, 0, 0);
    wait_done();
    chk("outside_done", done_cnt, d0 + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
